vga_timing_gen: RTL
===================

# vga_timing_gen

Parametrised VGA raster controller, successor to the fixed 640x480 `vga` block. It generates the horizontal and vertical pixel counters, sync and blank. It presents pixel addresses to the upstream pixel source and registers returned RGB into DAC outputs aligned with sync. Additions over `vga`:
- configurable timing and sync polarity;
- pixel-clock divider and enable;
- line/frame strobes and a frame counter.

## Interface
Parameters:
- COLOR_W, 10, bits per colour channel
- ADDR_W, 10, width of x/y address outputs
- H_ACTIVE / H_FP / H_SYNC / H_BP, 640 / 16 / 96 / 48, horizontal timing in pixels
- V_ACTIVE / V_FP / V_SYNC / V_BP, 480 / 10 / 2 / 33, vertical timing in lines
- HS_POL / VS_POL, 0 / 0, active sync level (0 = active-low)
- CLK_DIV, 1, i_clk cycles per pixel (>= 1)
- FRAME_W, 16, frame counter width

Ports:
- i_clk  in  1  clock
- i_reset  in  1  reset, asynchronous, active-high
- i_enable  in  1  pixel-tick enable; low freezes the raster
- i_vga_r / i_vga_g / i_vga_b  in  COLOR_W each  pixel colour for the previously presented address
- o_vga_r_DAC / o_vga_g_DAC / o_vga_b_DAC  out  COLOR_W each  registered colour, 0 when blanked
- o_x_addr / o_y_addr  out  ADDR_W each  current raster position
- o_vga_hs / o_vga_vs  out  1 each  sync, polarity per HS_POL/VS_POL
- o_vga_blank  out  1  high outside active region
- o_line_start  out  1  one-clock pulse on horizontal wrap
- o_frame_start  out  1  one-clock pulse on frame wrap
- o_frame_count  out  FRAME_W  completed frames, wraps modulo 2^FRAME_W

## Operation
- **Totals:** H_TOTAL = sum of H params; V_TOTAL = sum of V params.
- **Elaboration checks:** `$error` if H_TOTAL-1 or V_TOTAL-1 does not fit ADDR_W, or if CLK_DIV < 1.
- **Prescaler:** counts 0..CLK_DIV-1 while i_enable is high. The pixel tick is the cycle with count == CLK_DIV-1; it is every enabled cycle when CLK_DIV = 1. While i_enable is low, the prescaler and all state hold.
- **Counters:**
  - h counts 0..H_TOTAL-1 on each tick.
  - At h wrap, v increments; v wraps V_TOTAL-1 -> 0.
  - o_x_addr/o_y_addr are h/v directly.
- **Stage 2 (on each tick), driven from the pre-tick h/v:**
  - blank_d = !(h < H_ACTIVE && v < V_ACTIVE)
  - hs_d = H_ACTIVE+H_FP <= h < H_ACTIVE+H_FP+H_SYNC
  - vs_d = V_ACTIVE+V_FP <= v < V_ACTIVE+V_FP+V_SYNC
  - DAC outputs = blank_d ? 0 : i_vga_*
  - o_vga_hs = hs_d ? HS_POL : !HS_POL; o_vga_vs likewise with VS_POL.
- **Strobes:**
  - o_line_start pulses for one i_clk on the tick where h wraps to 0.
  - o_frame_start pulses on the tick where (h,v) wraps to (0,0); o_frame_count increments on the same tick.
  - Reset does not produce a frame_start.
- **Reset (any time, including mid-frame):** all of the following take effect immediately, asynchronously:
  - prescaler, h, v, o_x_addr, o_y_addr, DACs, o_frame_count = 0
  - o_vga_blank = 1
  - o_vga_hs = !HS_POL, o_vga_vs = !VS_POL
  - strobes = 0
  - The first tick after release advances to h = 1.

## Timing
- Address-to-output latency is exactly one pixel tick. Sync, blank and DAC for address (x,y) appear on the tick after (x,y) is presented.
- The upstream source must present valid RGB for o_x_addr/o_y_addr by the next tick.
- Line period: H_TOTAL*CLK_DIV clocks. Frame period: H_TOTAL*V_TOTAL*CLK_DIV clocks (420000 at defaults).
- Simultaneous h and v wrap: line_start and frame_start pulse in the same cycle.
- i_enable deasserted on a tick cycle: that tick is suppressed, and nothing advances.

## Structure
- Shared package `vga_timing_pkg` holds:
  - 640x480@60 default timing constants;
  - a `vga_timing_t` struct (active/fp/sync/bp);
  - a `total()` function.
- One sub-module, `vga_axis_counter`, instantiated twice (h, v):
  - parameters: ACTIVE, FP, SYNC, BP, W;
  - ports: advance in; count, active, in_sync, wrap out.

## Test plan
- **Async reset mid-frame:** assert i_reset at x=300, y=200, between clock edges -> same-instant reset values on every output; after release, o_x_addr = 1 at the first tick.
- **Default params, CLK_DIV=1:**
  - o_line_start every 800 clocks; o_frame_start every 420000 clocks.
  - o_vga_hs low for 96 clocks, beginning the clock after o_x_addr = 656.
  - o_vga_vs low for 2 lines.
- **RGB pass-through:** drive i_vga_r = o_x_addr[9:0] -> o_vga_r_DAC equals the previous tick's x when active and 0 when blank; blank high exactly at x >= 640 or y >= 480 (delayed one tick).
- **CLK_DIV=4:** addresses advance every 4 clocks; frame period 1680000 clocks; hs width 384 clocks.
- **Enable pause:** i_enable low for 10 clocks at x=100 -> all outputs frozen; next tick presents x=101.
- **Tiny config** (H 4/1/2/1, V 3/1/1/1, HS_POL=1, FRAME_W=2) -> hs active-high for 2 ticks per line; o_frame_count 0,1,2,3,0 across 4 frames at 8*6 = 48 ticks each.

Source files
------------

// File: rtl/vga_timing_pkg.sv
// Shared VGA timing definitions: 640x480@60 defaults, per-axis timing record
// and total-length helper used by the raster generator and its axis counters.
package vga_timing_pkg;

    typedef struct packed {
        logic [15:0] active;
        logic [15:0] fp;
        logic [15:0] sync;
        logic [15:0] bp;
    } vga_timing_t;

    localparam int unsigned DEF_H_ACTIVE = 640;
    localparam int unsigned DEF_H_FP     = 16;
    localparam int unsigned DEF_H_SYNC   = 96;
    localparam int unsigned DEF_H_BP     = 48;

    localparam int unsigned DEF_V_ACTIVE = 480;
    localparam int unsigned DEF_V_FP     = 10;
    localparam int unsigned DEF_V_SYNC   = 2;
    localparam int unsigned DEF_V_BP     = 33;

    localparam vga_timing_t VGA_640X480_H = '{
        active: 16'(DEF_H_ACTIVE),
        fp:     16'(DEF_H_FP),
        sync:   16'(DEF_H_SYNC),
        bp:     16'(DEF_H_BP)
    };

    localparam vga_timing_t VGA_640X480_V = '{
        active: 16'(DEF_V_ACTIVE),
        fp:     16'(DEF_V_FP),
        sync:   16'(DEF_V_SYNC),
        bp:     16'(DEF_V_BP)
    };

    function automatic int unsigned total(input vga_timing_t t);
        return int'(t.active) + int'(t.fp) + int'(t.sync) + int'(t.bp);
    endfunction

endpackage

// File: rtl/vga_axis_counter.sv
// One raster axis: free-running position counter with active/sync decode
// and a wrap flag that is high while the count sits on its last position.
module vga_axis_counter
    import vga_timing_pkg::*;
#(
    parameter int unsigned ACTIVE = DEF_H_ACTIVE,
    parameter int unsigned FP     = DEF_H_FP,
    parameter int unsigned SYNC   = DEF_H_SYNC,
    parameter int unsigned BP     = DEF_H_BP,
    parameter int unsigned W      = 10
) (
    input  logic         i_clk,
    input  logic         i_reset,
    input  logic         advance,
    output logic [W-1:0] count,
    output logic         active,
    output logic         in_sync,
    output logic         wrap
);

    localparam vga_timing_t TIMING = '{
        active: 16'(ACTIVE),
        fp:     16'(FP),
        sync:   16'(SYNC),
        bp:     16'(BP)
    };
    localparam int unsigned TOTAL      = total(TIMING);
    localparam logic [W-1:0] LAST      = W'(TOTAL - 1);
    localparam int unsigned SYNC_START = ACTIVE + FP;
    localparam int unsigned SYNC_END   = ACTIVE + FP + SYNC;

    logic [31:0] count_ext;

    assign count_ext = 32'(count);
    assign wrap      = (count == LAST);
    assign active    = (count_ext < ACTIVE);
    assign in_sync   = (count_ext >= SYNC_START) && (count_ext < SYNC_END);

    always_ff @(posedge i_clk or posedge i_reset) begin
        if (i_reset) begin
            count <= '0;
        end else if (advance) begin
            count <= wrap ? '0 : count + 1'b1;
        end
    end

endmodule

// File: rtl/vga_timing_gen.sv
// Parametrised VGA raster controller: prescaled pixel tick, h/v counters,
// registered sync/blank/DAC one tick behind the presented address, strobes.
module vga_timing_gen
    import vga_timing_pkg::*;
#(
    parameter int unsigned COLOR_W  = 10,
    parameter int unsigned ADDR_W   = 10,
    parameter int unsigned H_ACTIVE = DEF_H_ACTIVE,
    parameter int unsigned H_FP     = DEF_H_FP,
    parameter int unsigned H_SYNC   = DEF_H_SYNC,
    parameter int unsigned H_BP     = DEF_H_BP,
    parameter int unsigned V_ACTIVE = DEF_V_ACTIVE,
    parameter int unsigned V_FP     = DEF_V_FP,
    parameter int unsigned V_SYNC   = DEF_V_SYNC,
    parameter int unsigned V_BP     = DEF_V_BP,
    parameter bit          HS_POL   = 1'b0,
    parameter bit          VS_POL   = 1'b0,
    parameter int unsigned CLK_DIV  = 1,
    parameter int unsigned FRAME_W  = 16
) (
    input  logic               i_clk,
    input  logic               i_reset,
    input  logic               i_enable,
    input  logic [COLOR_W-1:0] i_vga_r,
    input  logic [COLOR_W-1:0] i_vga_g,
    input  logic [COLOR_W-1:0] i_vga_b,
    output logic [COLOR_W-1:0] o_vga_r_DAC,
    output logic [COLOR_W-1:0] o_vga_g_DAC,
    output logic [COLOR_W-1:0] o_vga_b_DAC,
    output logic [ADDR_W-1:0]  o_x_addr,
    output logic [ADDR_W-1:0]  o_y_addr,
    output logic               o_vga_hs,
    output logic               o_vga_vs,
    output logic               o_vga_blank,
    output logic               o_line_start,
    output logic               o_frame_start,
    output logic [FRAME_W-1:0] o_frame_count
);

    localparam int unsigned H_TOTAL = H_ACTIVE + H_FP + H_SYNC + H_BP;
    localparam int unsigned V_TOTAL = V_ACTIVE + V_FP + V_SYNC + V_BP;
    localparam int unsigned DIV_W   = (CLK_DIV > 1) ? $clog2(CLK_DIV) : 1;
    localparam logic [DIV_W-1:0] DIV_LAST = DIV_W'(CLK_DIV - 1);

    if (((H_TOTAL - 1) >> ADDR_W) != 0) begin : g_h_fit_check
        $error("vga_timing_gen: H_TOTAL-1 does not fit in ADDR_W bits");
    end
    if (((V_TOTAL - 1) >> ADDR_W) != 0) begin : g_v_fit_check
        $error("vga_timing_gen: V_TOTAL-1 does not fit in ADDR_W bits");
    end
    if (CLK_DIV < 1) begin : g_div_check
        $error("vga_timing_gen: CLK_DIV must be at least 1");
    end

    logic [DIV_W-1:0]  presc;
    logic              tick;
    logic [ADDR_W-1:0] h_count;
    logic [ADDR_W-1:0] v_count;
    logic              h_active;
    logic              v_active;
    logic              h_in_sync;
    logic              v_in_sync;
    logic              h_wrap;
    logic              v_wrap;
    logic              v_advance;
    logic              blank_d;

    // With CLK_DIV = 1 the prescaler is stuck at 0, so every enabled cycle ticks.
    assign tick = i_enable && (presc == DIV_LAST);

    always_ff @(posedge i_clk or posedge i_reset) begin
        if (i_reset) begin
            presc <= '0;
        end else if (i_enable) begin
            presc <= tick ? '0 : presc + 1'b1;
        end
    end

    assign v_advance = tick && h_wrap;

    vga_axis_counter #(
        .ACTIVE (H_ACTIVE),
        .FP     (H_FP),
        .SYNC   (H_SYNC),
        .BP     (H_BP),
        .W      (ADDR_W)
    ) u_h_counter (
        .i_clk   (i_clk),
        .i_reset (i_reset),
        .advance (tick),
        .count   (h_count),
        .active  (h_active),
        .in_sync (h_in_sync),
        .wrap    (h_wrap)
    );

    vga_axis_counter #(
        .ACTIVE (V_ACTIVE),
        .FP     (V_FP),
        .SYNC   (V_SYNC),
        .BP     (V_BP),
        .W      (ADDR_W)
    ) u_v_counter (
        .i_clk   (i_clk),
        .i_reset (i_reset),
        .advance (v_advance),
        .count   (v_count),
        .active  (v_active),
        .in_sync (v_in_sync),
        .wrap    (v_wrap)
    );

    assign o_x_addr = h_count;
    assign o_y_addr = v_count;
    assign blank_d  = !(h_active && v_active);

    // Stage 2 samples the pre-tick position, so outputs trail the address by one tick.
    always_ff @(posedge i_clk or posedge i_reset) begin
        if (i_reset) begin
            o_vga_r_DAC   <= '0;
            o_vga_g_DAC   <= '0;
            o_vga_b_DAC   <= '0;
            o_vga_blank   <= 1'b1;
            o_vga_hs      <= ~HS_POL;
            o_vga_vs      <= ~VS_POL;
            o_line_start  <= 1'b0;
            o_frame_start <= 1'b0;
            o_frame_count <= '0;
        end else begin
            o_line_start  <= tick && h_wrap;
            o_frame_start <= tick && h_wrap && v_wrap;
            if (tick) begin
                o_vga_blank <= blank_d;
                o_vga_hs    <= h_in_sync ? HS_POL : ~HS_POL;
                o_vga_vs    <= v_in_sync ? VS_POL : ~VS_POL;
                o_vga_r_DAC <= blank_d ? '0 : i_vga_r;
                o_vga_g_DAC <= blank_d ? '0 : i_vga_g;
                o_vga_b_DAC <= blank_d ? '0 : i_vga_b;
                if (h_wrap && v_wrap) begin
                    o_frame_count <= o_frame_count + 1'b1;
                end
            end
        end
    end

endmodule
